// File: rtl/mem_req_arbiter_if.sv
// Requester (instruction/data OBI ports) and storage-controller signal bundle of mem_req_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_req_arbiter_if #(
   parameter int unsigned MEM_W = 32
);
   logic               hold;
   logic               i_req;
   logic               i_gnt;
   logic [31:0]        i_addr;
   logic               i_rvalid;
   logic [31:0]        i_rdata;
   logic               d_req;
   logic               d_gnt;
   logic               d_we;
   logic [MEM_W/8-1:0] d_be;
   logic [31:0]        d_addr;
   logic [31:0]        d_wdata;
   logic               d_rvalid;
   logic [31:0]        d_rdata;
   logic               err;
   logic               memory_access;
   logic               memory_is_writing;
   logic [31:0]        addr;
   logic [31:0]        d_in;
   logic [MEM_W/8-1:0] mem_be;
   logic               external_storage_access;
   logic [31:0]        d_out;
   logic               out_valid;

   modport slave (
      input  hold, i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, d_out, out_valid,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err,
             memory_access, memory_is_writing, addr, d_in, mem_be, external_storage_access
   );

   modport master (
      output hold, i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, d_out, out_valid,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err,
             memory_access, memory_is_writing, addr, d_in, mem_be, external_storage_access
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fetch and data OBI ports onto one memory_access channel (IDLE->ISSUE->GAP).
// Optional ISSUE-state timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
   parameter int unsigned MEM_W          = 32,
   parameter logic [31:0] EXT_BASE       = 32'h0000_2000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic              clk,
   input logic              rst,
   mem_req_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t             state_q;
   logic               lastData_q;
   logic               ownerData_q;
   logic               memAccess_q;
   logic               writing_q;
   logic               ext_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [MEM_W/8-1:0] be_q;
   logic               iRvalid_q;
   logic               dRvalid_q;
   logic               err_q;
   logic [31:0]        iRdata_q;
   logic [31:0]        dRdata_q;

   logic               canGrant;
   logic               grantData;
   logic               grantInstr;
   logic [31:0]        reqAddr;
   logic               finish;
   logic               finishErr;
   logic [31:0]        finishData;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned         TimerW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TimerW-1:0]   TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
   logic [TimerW-1:0]              timer_q;
`endif

   // On a tie the port that did not win last time gets the grant.
   assign canGrant   = rst && (state_q == IDLE) && !bus.hold;
   assign grantData  = canGrant && bus.d_req && (!bus.i_req || !lastData_q);
   assign grantInstr = canGrant && bus.i_req && !grantData;
   assign reqAddr    = grantData ? bus.d_addr : bus.i_addr;

   always_comb begin
      finish     = 1'b0;
      finishErr  = 1'b0;
      finishData = bus.d_out;
      if (state_q == ISSUE) begin
         if (bus.out_valid) begin
            finish = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
         end else if (timer_q == TimerLast) begin
            finish     = 1'b1;
            finishErr  = 1'b1;
            finishData = 32'hDEAD_BEEF;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         lastData_q  <= 1'b0;
         ownerData_q <= 1'b0;
         memAccess_q <= 1'b0;
         writing_q   <= 1'b0;
         ext_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         iRvalid_q   <= 1'b0;
         dRvalid_q   <= 1'b0;
         err_q       <= 1'b0;
         iRdata_q    <= '0;
         dRdata_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         timer_q     <= '0;
`endif
      end else begin
         iRvalid_q <= 1'b0;
         dRvalid_q <= 1'b0;
         err_q     <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grantData || grantInstr) begin
                  lastData_q  <= grantData;
                  ownerData_q <= grantData;
                  memAccess_q <= 1'b1;
                  writing_q   <= grantData && bus.d_we;
                  ext_q       <= reqAddr >= EXT_BASE;
                  addr_q      <= {2'b00, reqAddr[31:2]};
                  wdata_q     <= grantData ? bus.d_wdata : '0;
                  be_q        <= grantData ? bus.d_be : '1;
`ifdef MEM_ARB_TIMEOUT_EN
                  timer_q     <= '0;
`endif
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (finish) begin
                  // Downstream fields are released together with memory_access.
                  memAccess_q <= 1'b0;
                  writing_q   <= 1'b0;
                  ext_q       <= 1'b0;
                  addr_q      <= '0;
                  wdata_q     <= '0;
                  be_q        <= '0;
                  err_q       <= finishErr;
                  if (ownerData_q) begin
                     dRvalid_q <= 1'b1;
                     dRdata_q  <= (writing_q && !finishErr) ? 32'h0 : finishData;
                  end else begin
                     iRvalid_q <= 1'b1;
                     iRdata_q  <= finishData;
                  end
                  state_q <= GAP;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else begin
                  timer_q <= timer_q + 1'b1;
               end
`endif
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.i_gnt                   = grantInstr;
   assign bus.d_gnt                   = grantData;
   assign bus.i_rvalid                = iRvalid_q;
   assign bus.i_rdata                 = iRdata_q;
   assign bus.d_rvalid                = dRvalid_q;
   assign bus.d_rdata                 = dRdata_q;
   assign bus.err                     = err_q;
   assign bus.memory_access           = memAccess_q;
   assign bus.memory_is_writing       = writing_q;
   assign bus.addr                    = addr_q;
   assign bus.d_in                    = wdata_q;
   assign bus.mem_be                  = be_q;
   assign bus.external_storage_access = ext_q;

endmodule
